// File: rtl/operand_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : operand_fetch_stage
// Description : Decode / operand-fetch stage sitting between the IF/ID
//               register and the execute stage. Drives the register-file
//               read addresses straight from the instruction and bypasses a
//               same-cycle writeback into the operands. It also detects a
//               load-use hazard against the instruction last issued into
//               ID/EX, and captures operands and control into the ID/EX
//               pipeline register. Downstream stall and flush are honoured.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock            system clock, all state updates on rising edge
//   ctrl_reset       synchronous active-low reset (0 = reset)
//   if_valid         IF/ID holds a valid instruction
//   if_insn/if_pc    instruction word and its PC
//   ctrl_readRegA/B  regfile read addresses (rs / rt), combinational
//   data_readRegA/B  regfile read data
//   wb_writeEnable   writeback is writing the regfile this cycle
//   wb_writeReg      writeback destination register
//   wb_data          writeback data
//   ex_stall         execute cannot accept, hold ID/EX
//   ex_flush         squash the ID instruction and ID/EX contents
//   id_stall         IF/ID must hold (combinational)
//   ex_valid .. ex_isLoad  registered ID/EX contents
// ============================================================================
module operand_fetch_stage #(
    parameter logic [5:0] LOAD_OPCODE  = 6'b100011,
    parameter logic [5:0] STORE_OPCODE = 6'b101011
) (
    input  logic        clock,
    input  logic        ctrl_reset,
    input  logic        if_valid,
    input  logic [31:0] if_insn,
    input  logic [31:0] if_pc,
    output logic [4:0]  ctrl_readRegA,
    output logic [4:0]  ctrl_readRegB,
    input  logic [31:0] data_readRegA,
    input  logic [31:0] data_readRegB,
    input  logic        wb_writeEnable,
    input  logic [4:0]  wb_writeReg,
    input  logic [31:0] wb_data,
    input  logic        ex_stall,
    input  logic        ex_flush,
    output logic        id_stall,
    output logic        ex_valid,
    output logic [31:0] ex_insn,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_opA,
    output logic [31:0] ex_opB,
    output logic [4:0]  ex_rd,
    output logic        ex_isLoad
);

    localparam logic [5:0] c_OP_SPECIAL = 6'b000000;
    localparam logic [5:0] c_OP_J       = 6'b000010;
    localparam logic [5:0] c_OP_JAL     = 6'b000011;
    localparam logic [5:0] c_OP_BEQ     = 6'b000100;
    localparam logic [5:0] c_OP_BNE     = 6'b000101;
    localparam logic [2:0] c_OP_IMM_HI  = 3'b001;
    localparam logic [4:0] c_REG_ZERO   = 5'd0;
    localparam logic [4:0] c_REG_LINK   = 5'd31;

    // ------------------------------------------------------------------
    // Instruction field extraction
    // ------------------------------------------------------------------
    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd_field;

    assign opcode   = if_insn[31:26];
    assign rs       = if_insn[25:21];
    assign rt       = if_insn[20:16];
    assign rd_field = if_insn[15:11];

    assign ctrl_readRegA = rs;
    assign ctrl_readRegB = rt;

    // ------------------------------------------------------------------
    // Destination and source-usage decode
    // ------------------------------------------------------------------
    logic [4:0] dest;
    logic       uses_rs;
    logic       uses_rt;
    logic       is_load;

    always_comb begin
        dest = c_REG_ZERO;
        if (opcode == c_OP_SPECIAL) begin
            dest = rd_field;
        end else if ((opcode[5:3] == c_OP_IMM_HI) || (opcode == LOAD_OPCODE)) begin
            dest = rt;
        end else if (opcode == c_OP_JAL) begin
            dest = c_REG_LINK;
        end
    end

    // Jumps carry no register sources; everything else reads rs.
    assign uses_rs = (opcode != c_OP_J) && (opcode != c_OP_JAL);
    // Only R-type, stores and the two compare-branches read rt; for
    // immediates and loads rt is the destination, not a source.
    assign uses_rt = (opcode == c_OP_SPECIAL) || (opcode == STORE_OPCODE) ||
                     (opcode == c_OP_BEQ)     || (opcode == c_OP_BNE);
    assign is_load = (opcode == LOAD_OPCODE);

    // ------------------------------------------------------------------
    // Operand selection with same-cycle writeback bypass.
    // Register zero is hard-wired to zero even if the regfile or a
    // writeback claims otherwise.
    // ------------------------------------------------------------------
    logic [31:0] op_a;
    logic [31:0] op_b;

    always_comb begin
        op_a = data_readRegA;
        if (rs == c_REG_ZERO) begin
            op_a = '0;
        end else if (wb_writeEnable && (wb_writeReg == rs)) begin
            op_a = wb_data;
        end
    end

    always_comb begin
        op_b = data_readRegB;
        if (rt == c_REG_ZERO) begin
            op_b = '0;
        end else if (wb_writeEnable && (wb_writeReg == rt)) begin
            op_b = wb_data;
        end
    end

    // ------------------------------------------------------------------
    // Load-use hazard against the instruction currently in ID/EX
    // ------------------------------------------------------------------
    logic ex_valid_q;
    logic [31:0] ex_insn_q;
    logic [31:0] ex_pc_q;
    logic [31:0] ex_opA_q;
    logic [31:0] ex_opB_q;
    logic [4:0]  ex_rd_q;
    logic        ex_isLoad_q;

    logic hazard;

    assign hazard = if_valid && ex_valid_q && ex_isLoad_q && (ex_rd_q != c_REG_ZERO) &&
                    ((uses_rs && (rs == ex_rd_q)) || (uses_rt && (rt == ex_rd_q)));

    // A flush kills the ID instruction, so there is nothing left to hold.
    assign id_stall = ctrl_reset && !ex_flush && (ex_stall || hazard);

    // ------------------------------------------------------------------
    // ID/EX next-state logic (reset handled in the register block)
    // ------------------------------------------------------------------
    logic        ex_valid_d;
    logic [31:0] ex_insn_d;
    logic [31:0] ex_pc_d;
    logic [31:0] ex_opA_d;
    logic [31:0] ex_opB_d;
    logic [4:0]  ex_rd_d;
    logic        ex_isLoad_d;

    always_comb begin
        ex_valid_d  = ex_valid_q;
        ex_insn_d   = ex_insn_q;
        ex_pc_d     = ex_pc_q;
        ex_opA_d    = ex_opA_q;
        ex_opB_d    = ex_opB_q;
        ex_rd_d     = ex_rd_q;
        ex_isLoad_d = ex_isLoad_q;

        if (ex_flush) begin
            ex_valid_d  = 1'b0;
            ex_rd_d     = c_REG_ZERO;
            ex_isLoad_d = 1'b0;
        end else if (ex_stall) begin
            // Hold everything; operands are not re-bypassed here and are
            // re-read from the regfile once the stall releases.
        end else if (hazard) begin
            // Bubble: the dependent instruction stays in IF/ID one cycle.
            ex_valid_d  = 1'b0;
            ex_rd_d     = c_REG_ZERO;
            ex_isLoad_d = 1'b0;
        end else begin
            ex_valid_d  = if_valid;
            ex_insn_d   = if_insn;
            ex_pc_d     = if_pc;
            ex_opA_d    = op_a;
            ex_opB_d    = op_b;
            // An invalid slot must never look like a writer or a load.
            ex_rd_d     = if_valid ? dest : c_REG_ZERO;
            ex_isLoad_d = if_valid && is_load;
        end
    end

    always_ff @(posedge clock) begin
        if (!ctrl_reset) begin
            ex_valid_q  <= 1'b0;
            ex_insn_q   <= '0;
            ex_pc_q     <= '0;
            ex_opA_q    <= '0;
            ex_opB_q    <= '0;
            ex_rd_q     <= '0;
            ex_isLoad_q <= 1'b0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_insn_q   <= ex_insn_d;
            ex_pc_q     <= ex_pc_d;
            ex_opA_q    <= ex_opA_d;
            ex_opB_q    <= ex_opB_d;
            ex_rd_q     <= ex_rd_d;
            ex_isLoad_q <= ex_isLoad_d;
        end
    end

    assign ex_valid  = ex_valid_q;
    assign ex_insn   = ex_insn_q;
    assign ex_pc     = ex_pc_q;
    assign ex_opA    = ex_opA_q;
    assign ex_opB    = ex_opB_q;
    assign ex_rd     = ex_rd_q;
    assign ex_isLoad = ex_isLoad_q;

endmodule
`default_nettype wire
